// File: rtl/flappy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flappy_pkg
//  Description : Shared screen/sprite constants, FSM state encodings and a
//                BCD digit helper for the flappy game datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package flappy_pkg;

    // Screen geometry
    localparam int SCREEN_W         = 800;
    localparam int SCREEN_H         = 525;
    localparam int PIPE_OFFSCREEN_X = 1000;

    // Sprite geometry (pixels)
    localparam int BIRD_X  = 200;
    localparam int BIRD_W  = 34;
    localparam int BIRD_H  = 24;
    localparam int PIPE_W  = 52;
    localparam int GAP_H   = 150;
    localparam int FLOOR_Y = 480;

    // Game FSM states, one-hot
    localparam logic [2:0] ST_IDLE = 3'b001;
    localparam logic [2:0] ST_PLAY = 3'b010;
    localparam logic [2:0] ST_LOST = 3'b100;

    // Increment one BCD digit; bit 4 of the result is the carry out (9 -> 0)
    function automatic logic [4:0] bcd_digit_inc(input logic [3:0] d);
        if (d == 4'd9)
            return 5'b1_0000;
        else
            return {1'b0, d + 4'd1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_counter3.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_counter3
//  Description : Three-digit BCD incrementer with synchronous clear and
//                saturation. Digits ripple a carry at 9 -> 0 and the count
//                never wraps past 999.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_counter3
    import flappy_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        i_inc,
    input  logic        i_clr,
    input  logic        i_sat,
    output logic [11:0] o_bcd
);

    logic [11:0] r_bcd;
    logic [4:0]  w_d0;
    logic [4:0]  w_d1;
    logic [4:0]  w_d2;
    logic [11:0] w_next;
    logic        w_at_max;

    // Per-digit increment with carry rippling from the units digit upward
    always_comb begin
        w_d0     = bcd_digit_inc(r_bcd[3:0]);
        w_d1     = w_d0[4] ? bcd_digit_inc(r_bcd[7:4])  : {1'b0, r_bcd[7:4]};
        w_d2     = w_d1[4] ? bcd_digit_inc(r_bcd[11:8]) : {1'b0, r_bcd[11:8]};
        w_next   = {w_d2[3:0], w_d1[3:0], w_d0[3:0]};
        w_at_max = (r_bcd == 12'h999);
    end

    // Count register: clear wins, then saturating increment
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            r_bcd <= 12'h000;
        else if (i_clr)
            r_bcd <= 12'h000;
        else if (i_inc && !i_sat && !w_at_max)
            r_bcd <= w_next;
    end

    assign o_bcd = r_bcd;

endmodule
`default_nettype wire

// File: rtl/pipe_collision_score.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_collision_score
//  Description : Per-tick collision and scoring for the bird versus the
//                current pipe. Three-stage pipeline (snapshot, geometry
//                flags, FSM/score update) with a fixed 2-cycle latency from
//                the Tick sample to the outputs. Drives the sticky Lost flag
//                and a binary + BCD score.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_collision_score #(
    parameter int BIRD_X    = flappy_pkg::BIRD_X,
    parameter int BIRD_W    = flappy_pkg::BIRD_W,
    parameter int BIRD_H    = flappy_pkg::BIRD_H,
    parameter int PIPE_W    = flappy_pkg::PIPE_W,
    parameter int GAP_H     = flappy_pkg::GAP_H,
    parameter int FLOOR_Y   = flappy_pkg::FLOOR_Y,
    parameter int HIT_TICKS = 2,
    parameter int SCORE_MAX = 999
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Tick,
    input  logic [9:0]  PipePosX,
    input  logic [9:0]  PipePosY,
    input  logic [9:0]  BirdPosY,
    output logic        Lost,
    output logic [9:0]  Score,
    output logic [11:0] ScoreBCD,
    output logic        ScoreInc,
    output logic        Busy
);

    import flappy_pkg::*;

    // Geometry is evaluated in 11 bits so the off-screen X (1000) plus the
    // pipe width cannot wrap.
    localparam logic [10:0] c_bird_l  = 11'(BIRD_X);
    localparam logic [10:0] c_bird_r  = 11'(BIRD_X + BIRD_W);
    localparam logic [10:0] c_bird_h  = 11'(BIRD_H);
    localparam logic [10:0] c_pipe_w  = 11'(PIPE_W);
    localparam logic [10:0] c_gap_h   = 11'(GAP_H);
    localparam logic [10:0] c_floor_y = 11'(FLOOR_Y);
    localparam int          HW        = $clog2(HIT_TICKS + 1);
    localparam logic [HW-1:0] c_hit_max   = HW'(HIT_TICKS);
    localparam logic [9:0]    c_score_max = 10'(SCORE_MAX);

    logic [2:0]    r_state;
    logic [2:0]    w_next_state;

    logic [9:0]    r_snap_px;
    logic [9:0]    r_snap_py;
    logic [9:0]    r_snap_by;
    logic          r_s1_valid;

    logic [10:0]   w_px;
    logic [10:0]   w_py;
    logic [10:0]   w_by;
    logic          w_hov;
    logic          w_ingap;
    logic          w_floor;
    logic          w_passed;
    logic          w_clear;

    logic          r_hov;
    logic          r_ingap;
    logic          r_floor;
    logic          r_passed;
    logic          r_clear;
    logic          r_s2_valid;

    logic          w_run;
    logic          w_start_game;
    logic          w_stage3;
    logic          w_coll;
    logic [HW-1:0] w_hit_next;
    logic          w_hit_reach;
    logic          w_sat;
    logic          w_score_inc;

    logic [HW-1:0] r_hit_cnt;
    logic          r_armed;
    logic [9:0]    r_score;
    logic          r_score_inc;

    // Qualifiers: results only flow while actively playing; leaving PLAY
    // drops whatever is still in flight.
    always_comb begin
        w_run        = (r_state == ST_PLAY) && Start;
        w_start_game = (r_state == ST_IDLE) && Start;
        w_stage3     = r_s2_valid && w_run;
        w_coll       = r_floor || (r_hov && !r_ingap);
        w_hit_next   = r_hit_cnt + 1'b1;
        w_hit_reach  = w_stage3 && w_coll && (w_hit_next >= c_hit_max);
        w_sat        = (r_score >= c_score_max);
        w_score_inc  = w_stage3 && r_armed && r_passed && !w_sat;
    end

    // Stage 1: snapshot positions on every Tick
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_snap_px  <= '0;
            r_snap_py  <= '0;
            r_snap_by  <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            if (Tick) begin
                r_snap_px <= PipePosX;
                r_snap_py <= PipePosY;
                r_snap_by <= BirdPosY;
            end
            r_s1_valid <= Tick && w_run;
        end
    end

    // Stage 2 geometry: overlap, gap, floor and pass/clear tests
    always_comb begin
        w_px     = {1'b0, r_snap_px};
        w_py     = {1'b0, r_snap_py};
        w_by     = {1'b0, r_snap_by};
        w_hov    = (w_px < c_bird_r) && ((w_px + c_pipe_w) > c_bird_l);
        w_ingap  = (w_by >= w_py) && ((w_by + c_bird_h) <= (w_py + c_gap_h));
        w_floor  = (w_by + c_bird_h) >= c_floor_y;
        w_passed = (w_px + c_pipe_w) <= c_bird_l;
        w_clear  = w_px > c_bird_r;
    end

    // Stage 2 register: hold the geometry flags for stage 3
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_hov      <= 1'b0;
            r_ingap    <= 1'b0;
            r_floor    <= 1'b0;
            r_passed   <= 1'b0;
            r_clear    <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            r_hov      <= w_hov;
            r_ingap    <= w_ingap;
            r_floor    <= w_floor;
            r_passed   <= w_passed;
            r_clear    <= w_clear;
            r_s2_valid <= r_s1_valid && w_run;
        end
    end

    // Stage 3: consecutive-hit counter, pipe arming and binary score
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_hit_cnt   <= '0;
            r_armed     <= 1'b1;
            r_score     <= '0;
            r_score_inc <= 1'b0;
        end else begin
            r_score_inc <= w_score_inc;
            if (w_start_game) begin
                r_hit_cnt <= '0;
                r_armed   <= 1'b1;
                r_score   <= '0;
            end else if (w_stage3) begin
                r_hit_cnt <= w_coll ? w_hit_next : '0;
                if (r_armed && r_passed)
                    r_armed <= 1'b0;
                if (r_clear)
                    r_armed <= 1'b1;
                if (w_score_inc)
                    r_score <= r_score + 10'd1;
            end
        end
    end

    // BCD mirror of the score, stepped by the same increment strobe
    bcd_counter3 u_bcd (
        .Clk   (Clk),
        .Reset (Reset),
        .i_inc (w_score_inc),
        .i_clr (w_start_game),
        .i_sat (w_sat),
        .o_bcd (ScoreBCD)
    );

    // FSM state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (Start)            w_next_state = ST_PLAY;
            ST_PLAY: if (!Start)           w_next_state = ST_IDLE;
                     else if (w_hit_reach) w_next_state = ST_LOST;
            ST_LOST: if (!Start)           w_next_state = ST_IDLE;
            default:                       w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        Busy = 1'b0;
        Lost = 1'b0;
        case (r_state)
            ST_PLAY: Busy = 1'b1;
            ST_LOST: Lost = 1'b1;
            default: ;
        endcase
    end

    assign Score    = r_score;
    assign ScoreInc = r_score_inc;

endmodule
`default_nettype wire

// File: doc/pipe_collision_score.md
Name: pipe_collision_score

Overview:
- Consumes the pipe generator's current pipe position and the bird's vertical position.
- Decides whether the bird has collided with the pipe or the floor, and counts pipes passed.
- Drives the game-over flag `Lost` back to the top-level FSM and to the pipe/bird movers, and drives the score to the display driver.
- Evaluation happens once per movement tick, not every clock, so it tracks the pipe's slow step rate.

Parameters:
- BIRD_X, 200: fixed left edge of the bird sprite (px).
- BIRD_W, 34: bird width (px).
- BIRD_H, 24: bird height (px).
- PIPE_W, 52: pipe width (px).
- GAP_H, 150: vertical opening height; the gap spans PipePosY .. PipePosY+GAP_H.
- FLOOR_Y, 480: the bird has hit the floor when BirdPosY+BIRD_H >= FLOOR_Y.
- HIT_TICKS, 2: number of consecutive colliding ticks required before `Lost` is set.
- SCORE_MAX, 999: score saturation value.

Ports:
- Clk  in  1  system clock; the only clock.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  game-run level from the top FSM (same signal the pipe generator uses).
- Tick  in  1  one-cycle strobe marking a movement step.
- PipePosX  in  10  pipe left edge. The value 1000 means off-screen and is legal.
- PipePosY  in  10  top of the pipe gap.
- BirdPosY  in  10  top of the bird sprite.
- Lost  out  1  game over; sticky.
- Score  out  10  binary count of pipes passed.
- ScoreBCD  out  12  three BCD digits of Score, hundreds in [11:8].
- ScoreInc  out  1  one-cycle pulse on each score increment.
- Busy  out  1  high while the FSM is in PLAY.

Behaviour:
- Reset (async, active-high): state=IDLE, Lost=0, Score=0, ScoreBCD=0, ScoreInc=0, Busy=0, hit_cnt=0, armed=1, pipeline valid bits=0.
- Arithmetic: all edge sums are computed zero-extended to 11 bits, so PipePosX=1000 plus PIPE_W cannot wrap.
- Pipeline:
  - Stage 1: on the Tick cycle (n), latch PipePosX, PipePosY and BirdPosY into snapshot registers; s1_valid=1.
  - Stage 2, at n+1: from the snapshot, compute the registered flags hov, ingap, floor, passed and clear.
    - hov = PipePosX < BIRD_X+BIRD_W && PipePosX+PIPE_W > BIRD_X
    - ingap = BirdPosY >= PipePosY && BirdPosY+BIRD_H <= PipePosY+GAP_H
    - floor = BirdPosY+BIRD_H >= FLOOR_Y
    - passed = PipePosX+PIPE_W <= BIRD_X
    - clear = PipePosX > BIRD_X+BIRD_W
  - Stage 3, at n+2: update the FSM, hit_cnt, Score, ScoreBCD, ScoreInc and Lost.
  - Tick-to-output latency is fixed at 2 cycles.
  - Ticks may arrive every cycle; the pipeline is fully pipelined.
- Collision: coll = floor || (hov && !ingap).
  - In PLAY, hit_cnt increments on each coll tick and clears to 0 on each non-coll tick.
  - Lost goes to 1 in the stage-3 cycle where hit_cnt would reach HIT_TICKS.
- Scoring:
  - armed && passed → Score+1 (saturating at SCORE_MAX), ScoreBCD updated in the same cycle, ScoreInc=1 for one cycle, armed=0.
  - clear → armed=1. This covers a pipe respawning at X=1000.
  - Collision and a score increment on the same tick: the score is counted first, then Lost is set.
  - At SCORE_MAX: Score holds and ScoreInc stays 0.
- ScoreBCD is kept as a parallel BCD incrementer with per-digit carry at 9→0, not a binary-to-BCD conversion.
- FSM:
  - IDLE: Busy=0, Lost=0. Start=1 → PLAY; on this transition Score=0, ScoreBCD=0, armed=1 and hit_cnt=0.
  - PLAY: Busy=1. Start=0 → IDLE with Score held and in-flight pipeline results discarded. hit_cnt reaching HIT_TICKS → LOST.
  - LOST: Lost=1, Score frozen, Ticks ignored. Start=0 → IDLE, which clears Lost.
- Ticks outside PLAY still load the snapshot, but stage 3 has no effect.
- Reset asserted mid-operation: all outputs return to reset values immediately, independent of Clk.

Decomposition:
- Shared package `flappy_pkg`:
  - screen constants (SCREEN_W=800, SCREEN_H=525, PIPE_OFFSCREEN_X=1000);
  - sprite size constants BIRD_X, BIRD_W, BIRD_H, PIPE_W, GAP_H, FLOOR_Y;
  - FSM state encodings IDLE/PLAY/LOST, one-hot, 3 bits.
- One natural sub-module: `bcd_counter3`, a 3-digit saturating BCD incrementer with inc, clr and sat inputs.

Test Plan:
1. Reset 3 cycles; Start=1; BirdPosY=250, PipePosY=190; sweep PipePosX 300→0, one Tick per step → Lost stays 0, exactly one ScoreInc pulse (2 cycles after the Tick with PipePosX=148), Score=1, ScoreBCD=0x001.
2. BirdPosY=100, PipePosY=190, PipePosX=220, two Ticks → Lost=1 two cycles after the second Tick; further Ticks leave Score unchanged.
3. Glitch rejection: coll on one Tick, non-coll on the next, coll on the third (HIT_TICKS=2) → Lost remains 0.
4. Floor: BirdPosY=460, PipePosX=1000, two Ticks → Lost=1. Then Start=0 → IDLE, Lost=0. Then Start=1 → Score=0.
5. Saturation: preload by passing 999 pipes (or force via hierarchical access), pass one more → Score=999, ScoreBCD=0x999, no ScoreInc.
6. Assert Reset asynchronously between a Tick and its stage-3 cycle in PLAY → all outputs 0 without waiting for a clock edge; no late ScoreInc after Reset is released.
